// File: rtl/vga_sync_gen.sv
// VGA raster timing generator: pixel strobe, raster coordinates, blanking and
// sync pulses, all derived from one free-running divider and two counters.
module vga_sync_gen #(
   parameter int   HD          = 640,
   parameter int   HF          = 16,
   parameter int   HS          = 96,
   parameter int   HB          = 48,
   parameter int   VD          = 480,
   parameter int   VF          = 10,
   parameter int   VS          = 2,
   parameter int   VB          = 33,
   parameter int   TICK_DIV    = 2,
   parameter logic SYNC_ACTIVE = 1'b0
) (
   input  logic       clk,
   input  logic       reset,
   output logic       p_tick,
   output logic [9:0] pixel_x,
   output logic [9:0] pixel_y,
   output logic       video_on,
   output logic       hsync,
   output logic       vsync,
   output logic       frame_end
);

   localparam int HT    = HD + HF + HS + HB;
   localparam int VT    = VD + VF + VS + VB;
   localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

   localparam logic [DIV_W-1:0] DIV_LAST     = DIV_W'(TICK_DIV - 1);
   localparam logic [9:0]       H_LAST       = 10'(HT - 1);
   localparam logic [9:0]       V_LAST       = 10'(VT - 1);
   localparam logic [9:0]       H_VIS        = 10'(HD);
   localparam logic [9:0]       V_VIS        = 10'(VD);
   localparam logic [9:0]       H_SYNC_FIRST = 10'(HD + HF);
   localparam logic [9:0]       H_SYNC_LAST  = 10'(HD + HF + HS - 1);
   localparam logic [9:0]       V_SYNC_FIRST = 10'(VD + VF);
   localparam logic [9:0]       V_SYNC_LAST  = 10'(VD + VF + VS - 1);

   logic [DIV_W-1:0] div_reg, div_next;
   logic [9:0]       h_count_reg, h_count_next;
   logic [9:0]       v_count_reg, v_count_next;
   logic             hsync_reg, hsync_next;
   logic             vsync_reg, vsync_next;

   // With TICK_DIV=1 the divider is stuck at 0 == DIV_LAST, so the strobe is constant.
   assign p_tick = (div_reg == DIV_LAST);

   always_comb begin
      div_next     = p_tick ? '0 : div_reg + DIV_W'(1);
      h_count_next = h_count_reg;
      v_count_next = v_count_reg;
      if (p_tick) begin
         if (h_count_reg == H_LAST) begin
            h_count_next = '0;
            v_count_next = (v_count_reg == V_LAST) ? '0 : v_count_reg + 10'd1;
         end else begin
            h_count_next = h_count_reg + 10'd1;
         end
      end
      // Syncs decode the next counts so the registered pulse lines up with pixel_x/pixel_y.
      hsync_next = (h_count_next >= H_SYNC_FIRST && h_count_next <= H_SYNC_LAST)
                   ? SYNC_ACTIVE : ~SYNC_ACTIVE;
      vsync_next = (v_count_next >= V_SYNC_FIRST && v_count_next <= V_SYNC_LAST)
                   ? SYNC_ACTIVE : ~SYNC_ACTIVE;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         div_reg     <= '0;
         h_count_reg <= '0;
         v_count_reg <= '0;
         hsync_reg   <= ~SYNC_ACTIVE;
         vsync_reg   <= ~SYNC_ACTIVE;
      end else begin
         div_reg     <= div_next;
         h_count_reg <= h_count_next;
         v_count_reg <= v_count_next;
         hsync_reg   <= hsync_next;
         vsync_reg   <= vsync_next;
      end
   end

   assign pixel_x   = h_count_reg;
   assign pixel_y   = v_count_reg;
   assign hsync     = hsync_reg;
   assign vsync     = vsync_reg;
   assign video_on  = (h_count_reg < H_VIS) && (v_count_reg < V_VIS);
   assign frame_end = p_tick && (h_count_reg == H_LAST) && (v_count_reg == V_LAST);

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: three parameterisations checked every clk against a
// closed-form raster model, plus hand-computed line/frame statistics.
module tb_vga_sync_gen;

   typedef struct packed {
      logic       pt;
      logic [9:0] x;
      logic [9:0] y;
      logic       von;
      logic       hs;
      logic       vs;
      logic       fe;
   } obs_t;

   logic clk = 1'b0;
   logic rst;
   logic phase1 = 1'b0;
   int   checks = 0;
   int   passes = 0;

   always #5 clk = ~clk;

   // Default mode: 640x480, TICK_DIV=2, negative sync
   logic       d_pt, d_von, d_hs, d_vs, d_fe;
   logic [9:0] d_x, d_y;
   vga_sync_gen u_def (
      .clk(clk), .reset(rst), .p_tick(d_pt), .pixel_x(d_x), .pixel_y(d_y),
      .video_on(d_von), .hsync(d_hs), .vsync(d_vs), .frame_end(d_fe));

   // Small raster (HT=25, VT=17) so whole frames fit in a short run
   logic       s_pt, s_von, s_hs, s_vs, s_fe;
   logic [9:0] s_x, s_y;
   vga_sync_gen #(.HD(16), .HF(2), .HS(3), .HB(4), .VD(10), .VF(2), .VS(2), .VB(3),
                  .TICK_DIV(2), .SYNC_ACTIVE(1'b0)) u_small (
      .clk(clk), .reset(rst), .p_tick(s_pt), .pixel_x(s_x), .pixel_y(s_y),
      .video_on(s_von), .hsync(s_hs), .vsync(s_vs), .frame_end(s_fe));

   // Default geometry, one pixel per clk, positive sync
   logic       f_pt, f_von, f_hs, f_vs, f_fe;
   logic [9:0] f_x, f_y;
   vga_sync_gen #(.TICK_DIV(1), .SYNC_ACTIVE(1'b1)) u_fast (
      .clk(clk), .reset(rst), .p_tick(f_pt), .pixel_x(f_x), .pixel_y(f_y),
      .video_on(f_von), .hsync(f_hs), .vsync(f_vs), .frame_end(f_fe));

   // Raster position as pure arithmetic on the number of clk edges since reset.
   function automatic obs_t model(int n, int td, int hd, int hf, int hs, int hb,
                                  int vd, int vf, int vs, int vb, logic sa);
      obs_t e;
      int ht = hd + hf + hs + hb;
      int vt = vd + vf + vs + vb;
      int p  = (n / td) % (ht * vt);
      int x  = p % ht;
      int y  = p / ht;
      e.pt  = ((n % td) == td - 1);
      e.x   = 10'(x);
      e.y   = 10'(y);
      e.von = (x < hd) && (y < vd);
      e.hs  = (x >= hd + hf && x < hd + hf + hs) ? sa : ~sa;
      e.vs  = (y >= vd + vf && y < vd + vf + vs) ? sa : ~sa;
      e.fe  = e.pt && (x == ht - 1) && (y == vt - 1);
      return e;
   endfunction

   task automatic check_obs(string nm, int n, obs_t act, obs_t exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s n=%0d got pt=%b x=%0d y=%0d von=%b hs=%b vs=%b fe=%b want pt=%b x=%0d y=%0d von=%b hs=%b vs=%b fe=%b",
                    nm, n, act.pt, act.x, act.y, act.von, act.hs, act.vs, act.fe,
                    exp.pt, exp.x, exp.y, exp.von, exp.hs, exp.vs, exp.fe);
   endtask

   task automatic check_int(string nm, int act, int exp);
      checks++;
      if (act == exp) passes++;
      else $display("FAIL %s got %0d want %0d", nm, act, exp);
   endtask

   // Edge counts since reset, one per instance
   int n_def, n_small, n_fast;
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         n_def   <= 0;
         n_small <= 0;
         n_fast  <= 0;
      end else begin
         n_def   <= n_def + 1;
         n_small <= n_small + 1;
         n_fast  <= n_fast + 1;
      end
   end

   always @(negedge clk) begin
      check_obs("def", n_def, {d_pt, d_x, d_y, d_von, d_hs, d_vs, d_fe},
                model(n_def, 2, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0));
      check_obs("small", n_small, {s_pt, s_x, s_y, s_von, s_hs, s_vs, s_fe},
                model(n_small, 2, 16, 2, 3, 4, 10, 2, 2, 3, 1'b0));
      check_obs("fast", n_fast, {f_pt, f_x, f_y, f_von, f_hs, f_vs, f_fe},
                model(n_fast, 1, 640, 16, 96, 48, 480, 10, 2, 33, 1'b1));
   end

   // Statistics gathered during the first run after reset release
   int def_hs_low = 0, def_first_pt = -1, def_y1 = -1;
   int sm_von = 0, sm_vs_low = 0, sm_fe_f0 = 0;
   int sm_fe_at[$];
   int fast_hs_hi = 0, fast_pt_low = 0, fast_y1 = -1;

   always @(negedge clk) begin
      if (phase1 && !rst) begin
         if (!d_hs && d_y == 10'd0) def_hs_low++;
         if (d_pt && def_first_pt < 0) def_first_pt = n_def;
         if (d_y == 10'd1 && def_y1 < 0) def_y1 = n_def;
         if (s_pt && n_small < 850) begin
            if (s_von) sm_von++;
            if (!s_vs) sm_vs_low++;
         end
         if (s_fe) begin
            sm_fe_at.push_back(n_small);
            if (n_small < 850) sm_fe_f0++;
         end
         if (n_fast < 800 && f_hs) fast_hs_hi++;
         if (!f_pt) fast_pt_low++;
         if (f_y == 10'd1 && fast_y1 < 0) fast_y1 = n_fast;
      end
   end

   initial begin
      bit found;
      rst = 1'b1;
      repeat (4) @(negedge clk);
      #1 rst = 1'b0;
      phase1 = 1'b1;
      $display("run 1: 3400 clk from reset release");
      repeat (3400) @(negedge clk);
      phase1 = 1'b0;
      #1;
      check_int("def_first_ptick_cycle", def_first_pt, 1);
      check_int("def_hsync_low_clks_line0", def_hs_low, 192);
      check_int("def_line_period_clks", def_y1, 1600);
      check_int("small_video_on_ticks_frame", sm_von, 160);
      check_int("small_vsync_low_ticks_frame", sm_vs_low, 50);
      check_int("small_frame_end_pulses_frame0", sm_fe_f0, 1);
      check_int("small_frame_end_count", sm_fe_at.size(), 4);
      if (sm_fe_at.size() >= 2) begin
         check_int("small_frame_end_first", sm_fe_at[0], 849);
         check_int("small_frame_end_second", sm_fe_at[1], 1699);
      end
      check_int("fast_hsync_high_clks_line0", fast_hs_hi, 96);
      check_int("fast_ptick_low_clks", fast_pt_low, 0);
      check_int("fast_line_period_clks", fast_y1, 800);

      $display("run 2: async reset at small raster (10,7)");
      found = 1'b0;
      for (int i = 0; i < 2000 && !found; i++) begin
         @(negedge clk);
         if (s_x == 10'd10 && s_y == 10'd7) found = 1'b1;
      end
      check_int("small_reached_10_7", int'(found), 1);
      #2 rst = 1'b1;
      #1;
      check_int("async_rst_x", int'(s_x), 0);
      check_int("async_rst_y", int'(s_y), 0);
      check_int("async_rst_hsync", int'(s_hs), 1);
      check_int("async_rst_vsync", int'(s_vs), 1);
      check_int("async_rst_ptick", int'(s_pt), 0);
      check_int("async_rst_def_x", int'(d_x), 0);
      check_int("async_rst_fast_hsync", int'(f_hs), 0);
      @(negedge clk);
      #1 rst = 1'b0;
      $display("run 3: 2000 clk after second release");
      repeat (2000) @(negedge clk);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
